ram_arbiter: RTL
================

# ram_arbiter

Shares one single-ported SRAM between the instruction-bus and data-bus memory paths. The block sits between `inst_bus`/`data_bus` (RAM-side outputs) and a single `fake_ram` or board SRAM controller. It serialises accesses, round-robins on contention, and generates per-port stall so the CPU pipeline holds until its access completes.

## Interface
- `ADDR_W`, 24: SRAM word-address width.
- `WAIT_CYCLES`, 1: cycles the SRAM enables are held per access (≥1).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_addr` in ADDR_W: instruction-port address.
- `inst_read` / `inst_write` in 1: instruction-port request strobes, level.
- `inst_wdata` in 32: instruction-port write data.
- `inst_byte_en` in 4: instruction-port byte enables.
- `inst_rdata` out 32: instruction-port read data, registered.
- `inst_stall` out 1: instruction port must hold its request.
- `data_addr`, `data_read`, `data_write`, `data_wdata`, `data_byte_en`, `data_rdata`, `data_stall`: the same set for the data port.
- `sram_addr` out ADDR_W: SRAM address, registered.
- `sram_wdata` out 32: SRAM write data, registered.
- `sram_byte_en` out 4: SRAM byte enables, registered.
- `sram_read_enable` / `sram_write_enable` out 1: SRAM strobes, registered.
- `sram_rdata` in 32: SRAM read data, valid in the last ACCESS cycle.

## Operation
- Port request: `req_x = x_read | x_write`. If both strobes are high, the access is a write. The `x_rdata` of that access is not updated.
- FSM states: IDLE, ACCESS, DONE.
  - **IDLE:** if any request is present, choose the grant, latch address, data, byte enables and op into the SRAM output registers, load the wait counter with WAIT_CYCLES-1, and go to ACCESS. Otherwise stay in IDLE with both enables 0.
  - **ACCESS:** enables held. When the counter reaches 0, capture `sram_rdata` into the granted port's `rdata` register (reads only), drop both enables, and go to DONE. Otherwise decrement the counter.
  - **DONE:** spend one cycle releasing the granted port, update `last_grant`, then go to IDLE.
- Grant rules:
  - If only one port requests, that port wins.
  - If both request, the port that is not `last_grant` wins.
  - `last_grant` resets to INST, so the data port wins the first tie.
- Stall, combinational: `x_stall = req_x & ~(state==DONE & grant==x)`. A requester sees stall=1 in its request cycle and in every cycle until DONE.
- A port that withdraws its request mid-access (pipeline flush) does not abort the access. The SRAM cycle completes, the read data is still registered, and stall is 0 because `req` is 0.
- `x_rdata` holds its value until the next completed read for port x.
- The address is passed through unchanged. No decoding is done here; the buses already decoded it.

## Timing
- Reset values: all SRAM outputs 0, both `rdata` 0, state IDLE, `last_grant` INST. `x_stall` follows its combinational equation (1 if `req_x`).
- If a request is first seen in IDLE at edge N:
  - Enables are high from cycle N+1 through N+WAIT_CYCLES.
  - DONE (stall=0, `rdata` valid) is in cycle N+1+WAIT_CYCLES.
- With WAIT_CYCLES=1 one access occupies 3 cycles. Back-to-back requests from one port get one access every 3 cycles.
- Under continuous contention the ports strictly alternate, so neither port waits more than 2×(WAIT_CYCLES+2) cycles.
- A request that arrives during ACCESS/DONE of the other port is sampled in the following IDLE.
- Reset asserted mid-access: at the next edge, state is IDLE, the enables are 0, and any partial access is discarded. `rdata` registers are cleared.
- The SRAM address and write data are stable for the whole ACCESS window. They are not altered by input changes after the grant.

## Test plan
- **Reset:** hold `rst` 2 cycles with `inst_read`=1 → all SRAM outputs 0, `inst_stall`=1, state IDLE; after release the read starts on the next edge.
- **Single read, WAIT_CYCLES=1:** `inst_read` at `inst_addr`=0x000010 with SRAM returning 0xDEADBEEF → `sram_read_enable` high for exactly 1 cycle, `inst_stall` low 2 cycles after the request edge, `inst_rdata`=0xDEADBEEF.
- **Contention:** `inst_read` and `data_write` (addr 0x20, data 0x12345678, byte_en 4'b0011) held together →
  - the data write is granted first; `inst_stall` stays 1 throughout;
  - the instruction read follows;
  - grant order D,I,D,I when both are held continuously.
- **Withdrawal:** `data_read` dropped during ACCESS → access completes, `data_stall`=0, and the next instruction request is serviced normally.
- **Read+write both set:** `data_read`=`data_write`=1 → `sram_write_enable`=1, `sram_read_enable`=0, `data_rdata` unchanged.
- **Reset mid-access, WAIT_CYCLES=3:** assert `rst` in the 2nd ACCESS cycle → next cycle both enables 0, state IDLE, `rdata` 0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   One CPU-side memory port as seen by the SRAM arbiter.
//   master : the bus (instruction or data path) issuing accesses
//   slave  : the arbiter serving them
// Signals:
//   addr     word address, passed through to the SRAM untouched
//   read     read request strobe (level)
//   write    write request strobe (level); wins over read when both set
//   wdata    write data
//   byte_en  write byte enables
//   rdata    registered read data, holds until the next completed read
//   stall    port must hold its request while high
interface ram_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [31:0]       wdata;
  logic [3:0]        byte_en;
  logic [31:0]       rdata;
  logic              stall;

  modport master (
    output addr, read, write, wdata, byte_en,
    input  rdata, stall
  );

  modport slave (
    input  addr, read, write, wdata, byte_en,
    output rdata, stall
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-ported SRAM between the instruction and data memory
//   paths. Accesses are serialised through IDLE -> ACCESS -> DONE; ties are
//   broken round-robin against the last granted port. Each port stalls from
//   its request cycle until its DONE cycle.
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   inst_bus           instruction-port bus (slave side)
//   data_bus           data-port bus (slave side)
//   sram_addr          registered SRAM address
//   sram_wdata         registered SRAM write data
//   sram_byte_en       registered SRAM byte enables
//   sram_read_enable   registered SRAM read strobe
//   sram_write_enable  registered SRAM write strobe
//   sram_rdata         SRAM read data, valid in the last ACCESS cycle
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winner
// ACCESS | SRAM enables held, wait counter running down
// DONE   | one-cycle release of the granted port
module ram_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      inst_bus,
  ram_arbiter_if.slave      data_bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_byte_en,
  output logic              sram_read_enable,
  output logic              sram_write_enable,
  input  logic [31:0]       sram_rdata
);

  // Counter only ever holds WAIT_CYCLES-1 down to 0.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant;
  logic              last_grant;
  logic [31:0]       inst_rdata_q;
  logic [31:0]       data_rdata_q;

  logic              inst_req;
  logic              data_req;
  logic              any_req;
  logic              grant_sel;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_byte_en;
  logic              access_end;
  logic              inst_stall_c;
  logic              data_stall_c;

  assign inst_req   = inst_bus.read | inst_bus.write;
  assign data_req   = data_bus.read | data_bus.write;
  assign any_req    = inst_req | data_req;
  assign access_end = (state == ACCESS) && (wait_cnt == '0);

  // Arbitration: a lone requester wins; on a tie the port that did not go
  // last wins.
  always_comb begin
    grant_sel = PORT_INST;
    if (inst_req && data_req) begin
      grant_sel = ~last_grant;
    end else if (data_req) begin
      grant_sel = PORT_DATA;
    end

    if (grant_sel == PORT_DATA) begin
      sel_addr    = data_bus.addr;
      sel_wdata   = data_bus.wdata;
      sel_byte_en = data_bus.byte_en;
      sel_write   = data_bus.write;
    end else begin
      sel_addr    = inst_bus.addr;
      sel_wdata   = inst_bus.wdata;
      sel_byte_en = inst_bus.byte_en;
      sel_write   = inst_bus.write;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs: stall is released only in the granted port's DONE cycle. A port
  // that withdrew its request sees no stall regardless of the access state.
  always_comb begin
    inst_stall_c = inst_req & ~((state == DONE) && (grant == PORT_INST));
    data_stall_c = data_req & ~((state == DONE) && (grant == PORT_DATA));
  end

  assign inst_bus.stall = inst_stall_c;
  assign data_bus.stall = data_stall_c;
  assign inst_bus.rdata = inst_rdata_q;
  assign data_bus.rdata = data_rdata_q;

  // Datapath: SRAM output registers are loaded only on grant, so bus changes
  // during ACCESS cannot disturb the SRAM cycle in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr         <= '0;
      sram_wdata        <= '0;
      sram_byte_en      <= '0;
      sram_read_enable  <= 1'b0;
      sram_write_enable <= 1'b0;
      wait_cnt          <= '0;
      grant             <= PORT_INST;
      last_grant        <= PORT_INST;
      inst_rdata_q      <= '0;
      data_rdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant             <= grant_sel;
            sram_addr         <= sel_addr;
            sram_wdata        <= sel_wdata;
            sram_byte_en      <= sel_byte_en;
            sram_write_enable <= sel_write;
            sram_read_enable  <= ~sel_write;
            wait_cnt          <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (access_end) begin
            sram_read_enable  <= 1'b0;
            sram_write_enable <= 1'b0;
            // The read strobe itself records whether this was a read.
            if (sram_read_enable) begin
              if (grant == PORT_DATA) begin
                data_rdata_q <= sram_rdata;
              end else begin
                inst_rdata_q <= sram_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          last_grant <= grant;
        end
        default: begin
          sram_read_enable  <= 1'b0;
          sram_write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
